// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings, FSM states, default width.
// MULDIV_FAST_MUL_EN (see muldiv_ctrl) selects a single-cycle multiplier; divide is always iterative.
package muldiv_pkg;

   localparam int MULDIV_WIDTH = 32;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration shared by multiply (shift-add) and divide (restoring shift-subtract).
// Multiply: acc + (mul_bit ? operand : 0), shifted right; shift_bit is the bit falling into the low word.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc,
   input  logic             mul_bit,
   input  logic             div_bit,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] acc_out,
   output logic             shift_bit
);

   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic             fits;

   always_comb begin
      addend  = mul_bit ? operand : '0;
      sum     = {1'b0, acc} + {1'b0, addend};
      // partial remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits
      shifted = {acc, div_bit};
      fits    = (shifted >= {1'b0, operand});
      if (is_div) begin
         acc_out   = fits ? WIDTH'(shifted - {1'b0, operand}) : WIDTH'(shifted);
         shift_bit = fits;
      end else begin
         acc_out   = sum[WIDTH:1];
         shift_bit = sum[0];
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; iterative datapath with sign pre/post correction.
// Define MULDIV_FAST_MUL_EN for a single-cycle '*' multiply (IDLE->FIX directly); divide is unchanged.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int              CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [WIDTH-1:0] acc_reg, acc_next;     // product high half, partial remainder, or raw x on div-by-zero
   logic [WIDTH-1:0] work_reg, work_next;   // multiplier shifting out / dividend shifting into quotient
   logic [WIDTH-1:0] opnd_reg, opnd_next;   // multiplicand or divisor magnitude
   logic             is_div_reg, is_div_next;
   logic             neg_q_reg, neg_q_next;
   logic             neg_r_reg, neg_r_next;
   logic             dz_reg, dz_next;
   logic [WIDTH-1:0] hi_reg, hi_next;
   logic [WIDTH-1:0] lo_reg, lo_next;
   logic             done_reg, done_next;
   logic             dbz_reg, dbz_next;
   logic             busy_reg, busy_next;

   logic             signed_op;
   logic             x_neg, y_neg;
   logic [WIDTH-1:0] x_mag, y_mag;
   logic [WIDTH-1:0] step_acc;
   logic             step_bit;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quot_fix, rem_fix;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod;
`endif

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div    (is_div_reg),
      .acc       (acc_reg),
      .mul_bit   (work_reg[0]),
      .div_bit   (work_reg[WIDTH-1]),
      .operand   (opnd_reg),
      .acc_out   (step_acc),
      .shift_bit (step_bit)
   );

   always_comb begin
      signed_op = (op == OP_MULT) || (op == OP_DIV);
      x_neg     = signed_op & x[WIDTH-1];
      y_neg     = signed_op & y[WIDTH-1];
      x_mag     = x_neg ? -x : x;
      y_mag     = y_neg ? -y : y;
`ifdef MULDIV_FAST_MUL_EN
      fast_prod = {{WIDTH{1'b0}}, x_mag} * {{WIDTH{1'b0}}, y_mag};
`endif
      prod_fix  = neg_q_reg ? -{acc_reg, work_reg} : {acc_reg, work_reg};
      quot_fix  = neg_q_reg ? -work_reg : work_reg;
      rem_fix   = neg_r_reg ? -acc_reg : acc_reg;
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      acc_next    = acc_reg;
      work_next   = work_reg;
      opnd_next   = opnd_reg;
      is_div_next = is_div_reg;
      neg_q_next  = neg_q_reg;
      neg_r_next  = neg_r_reg;
      dz_next     = dz_reg;
      hi_next     = hi_reg;
      lo_next     = lo_reg;
      done_next   = 1'b0;
      dbz_next    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     is_div_next = 1'b0;
                     neg_q_next  = x_neg ^ y_neg;
                     neg_r_next  = 1'b0;
                     dz_next     = 1'b0;
                     cnt_next    = '0;
`ifdef MULDIV_FAST_MUL_EN
                     {acc_next, work_next} = fast_prod;
                     state_next  = FIX;
`else
                     acc_next    = '0;
                     work_next   = y_mag;
                     opnd_next   = x_mag;
                     state_next  = CALC;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     is_div_next = 1'b1;
                     neg_q_next  = x_neg ^ y_neg;
                     neg_r_next  = x_neg;
                     cnt_next    = '0;
                     if (y == '0) begin
                        // HI must receive the unmodified dividend, so keep raw x rather than its magnitude
                        dz_next    = 1'b1;
                        acc_next   = x;
                        state_next = FIX;
                     end else begin
                        dz_next    = 1'b0;
                        acc_next   = '0;
                        work_next  = x_mag;
                        opnd_next  = y_mag;
                        state_next = CALC;
                     end
                  end
                  OP_MTHI: hi_next = x;
                  OP_MTLO: lo_next = x;
                  default: ;
               endcase
            end
         end
         CALC: begin
            if (cancel) begin
               state_next = IDLE;
            end else begin
               acc_next  = step_acc;
               work_next = is_div_reg ? {work_reg[WIDTH-2:0], step_bit}
                                      : {step_bit, work_reg[WIDTH-1:1]};
               cnt_next  = cnt_reg + 1'b1;
               if (cnt_reg == LAST_ITER) begin
                  state_next = FIX;
               end
            end
         end
         FIX: begin
            state_next = IDLE;
            if (!cancel) begin
               done_next = 1'b1;
               if (dz_reg) begin
                  hi_next  = acc_reg;
                  lo_next  = '1;
                  dbz_next = 1'b1;
               end else if (is_div_reg) begin
                  hi_next = rem_fix;
                  lo_next = quot_fix;
               end else begin
                  {hi_next, lo_next} = prod_fix;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         acc_reg    <= '0;
         work_reg   <= '0;
         opnd_reg   <= '0;
         is_div_reg <= 1'b0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         dz_reg     <= 1'b0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         done_reg   <= 1'b0;
         dbz_reg    <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         acc_reg    <= acc_next;
         work_reg   <= work_next;
         opnd_reg   <= opnd_next;
         is_div_reg <= is_div_next;
         neg_q_reg  <= neg_q_next;
         neg_r_reg  <= neg_r_next;
         dz_reg     <= dz_next;
         hi_reg     <= hi_next;
         lo_reg     <= lo_next;
         done_reg   <= done_next;
         dbz_reg    <= dbz_next;
         busy_reg   <= busy_next;
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign div_by_zero = dbz_reg;
   assign hi          = hi_reg;
   assign lo          = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: table of mul/div vectors plus MTHI/MTLO, cancel and reset sequences.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         cancel = 1'b0;
   logic [2:0]   op = 3'b000;
   logic [W-1:0] x = '0;
   logic [W-1:0] y = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   always #5 clk = ~clk;

   muldiv_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .x           (x),
      .y           (y),
      .cancel      (cancel),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      logic         is_mul;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int lat, busy_cnt, exp_lat;
      logic seen_done;

      vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1};
      vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1};
      vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0};
      vecs[3] = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 1'b0};
      vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
      vecs[5] = '{OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b0};
      vecs[6] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b1};
      vecs[7] = '{OP_DIV,   32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 1'b0};
      vecs[8] = '{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1'b0};
      vecs[9] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      check("reset_hi", 64'(hi), 64'h0);
      check("reset_lo", 64'(lo), 64'h0);
      check("reset_busy", 64'(busy), 64'h0);
      check("reset_done", 64'(done), 64'h0);
      check("reset_dbz", 64'(div_by_zero), 64'h0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         exp_lat = vecs[i].is_mul ? MUL_LAT : (vecs[i].dbz ? 1 : 33);
         @(posedge clk); #1;
         start = 1'b1; op = vecs[i].op; x = vecs[i].x; y = vecs[i].y;
         @(posedge clk); #1;                      // after E0
         busy_cnt = busy ? 1 : 0;
         // keep start high with a different op: must be ignored while busy
         op = OP_DIVU; x = 32'd9; y = 32'd3;
         @(posedge clk); #1;                      // after E1
         start = 1'b0;
         lat = 1;
         while (!done && lat < 60) begin
            busy_cnt += busy ? 1 : 0;
            @(posedge clk); #1;
            lat++;
         end
         $display("vec %0d op=%0d x=%h y=%h -> hi=%h lo=%h dbz=%0b lat=%0d busy=%0d",
                  i, vecs[i].op, vecs[i].x, vecs[i].y, hi, lo, div_by_zero, lat, busy_cnt);
         check($sformatf("v%0d_done", i), 64'(done), 64'h1);
         check($sformatf("v%0d_lat", i), 64'(lat), 64'(exp_lat));
         check($sformatf("v%0d_busycnt", i), 64'(busy_cnt), 64'(exp_lat));
         check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
         check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
         check($sformatf("v%0d_dbz", i), 64'(div_by_zero), 64'(vecs[i].dbz));
         check($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'h0);
         @(posedge clk); #1;
         check($sformatf("v%0d_done_pulse", i), 64'(done), 64'h0);
         check($sformatf("v%0d_dbz_pulse", i), 64'(div_by_zero), 64'h0);
      end

      // MTHI / MTLO preload
      start = 1'b1; op = OP_MTHI; x = 32'hDEADBEEF; y = '0;
      @(posedge clk); #1;
      op = OP_MTLO; x = 32'h0BADF00D;
      $display("mthi -> hi=%h busy=%0b done=%0b", hi, busy, done);
      check("mthi_hi", 64'(hi), 64'hDEADBEEF);
      check("mthi_busy", 64'(busy), 64'h0);
      check("mthi_done", 64'(done), 64'h0);
      @(posedge clk); #1;
      start = 1'b0;
      $display("mtlo -> hi=%h lo=%h busy=%0b", hi, lo, busy);
      check("mtlo_lo", 64'(lo), 64'h0BADF00D);
      check("mtlo_hi_kept", 64'(hi), 64'hDEADBEEF);
      check("mtlo_busy", 64'(busy), 64'h0);

      // DIVU cancelled in CALC cycle 10
      start = 1'b1; op = OP_DIVU; x = 32'd100; y = 32'd3;
      @(posedge clk); #1;                         // after E0
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;                                         // after E9: CALC cycle 10
      check("cancel_busy_before", 64'(busy), 64'h1);
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      $display("cancel -> busy=%0b hi=%h lo=%h done=%0b", busy, hi, lo, done);
      check("cancel_busy", 64'(busy), 64'h0);
      check("cancel_hi", 64'(hi), 64'hDEADBEEF);
      check("cancel_lo", 64'(lo), 64'h0BADF00D);
      seen_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done) seen_done = 1'b1;
         @(posedge clk); #1;
      end
      check("cancel_no_done", 64'(seen_done), 64'h0);
      check("cancel_hi_after", 64'(hi), 64'hDEADBEEF);

      // reset at CALC cycle 5 of a MULTU
      start = 1'b1; op = OP_MULTU; x = 32'h00010000; y = 32'h00010000;
      @(posedge clk); #1;                         // after E0
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;                                         // after E4: CALC cycle 5
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      $display("reset mid-op -> hi=%h lo=%h busy=%0b", hi, lo, busy);
      check("rst_hi", 64'(hi), 64'h0);
      check("rst_lo", 64'(lo), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      seen_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done) seen_done = 1'b1;
         @(posedge clk); #1;
      end
      check("rst_no_done", 64'(seen_done), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers of the MIPS core. The EX stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO, and the block runs an iterative shift-add multiplier or restoring divider over several cycles. It exposes `busy` so the hazard unit stalls MFHI/MFLO and further mul/div issue, and writes HI/LO atomically on completion.

## Interface
- `WIDTH`, 32, operand/HI/LO width; iteration count equals `WIDTH`.
- `clk` in 1, rising-edge clock.
- `rst` in 1, synchronous, active-high reset.
- `start` in 1, issue strobe; sampled only when `busy`=0.
- `op` in 3, 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x ignored.
- `x` in WIDTH, rs operand (dividend / MTHI/MTLO data).
- `y` in WIDTH, rt operand (divisor).
- `cancel` in 1, pipeline flush; aborts an operation in flight.
- `busy` out 1, high while state≠IDLE.
- `done` out 1, one-cycle pulse when HI/LO take a mul/div result.
- `div_by_zero` out 1, high with `done` when the finished DIV/DIVU had `y`=0.
- `hi` out WIDTH, HI register.
- `lo` out WIDTH, LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE + `start` + MUL/DIV op:
  - Latch operand magnitudes (signed ops) or raw values (unsigned ops), plus sign flags.
  - Clear the iteration counter and go to CALC.
- IDLE + `start` + MTHI/MTLO: write `x` to `hi`/`lo` at that edge. Stay IDLE, no `busy`, no `done`.
- CALC: one iteration per cycle.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
  - After iteration `WIDTH-1`, go to FIX.
- FIX: sign-correct and write HI/LO, pulse `done`, return to IDLE.
- Multiply: {hi,lo} = 64-bit product. Signed: negate the magnitude product if the operand signs differ.
- Divide: lo = quotient, hi = remainder. Signed rules:
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (any sign):
  - Skip CALC and go IDLE→FIX directly.
  - Result: lo=0xFFFFFFFF, hi=`x` unmodified.
  - `div_by_zero`=1 with `done`.
- `start` while `busy`: ignored, with no queueing.
- `cancel` in CALC or FIX: IDLE at the next edge. HI/LO unchanged, no `done`. `cancel` beats FIX completion in the same cycle.
- `cancel` in IDLE: no effect. A `start` in the same cycle is still accepted; the hazard unit must not assert `start` on flushed instructions.

## Timing
- Start sampled at edge E0.
- Mul/div: CALC occupies E1..E`WIDTH`. FIX edge E`WIDTH`+1 writes HI/LO and sets `done`. Latency 33 cycles at WIDTH=32.
- Divide by zero: result at E1, latency 1.
- MTHI/MTLO: value visible after E0.
- `busy` is registered: high from after E0 until the FIX edge.
  - The hazard unit must also stall MFHI/MFLO in the issue cycle itself (`start`=1).
- `done` and `div_by_zero` are registered one-cycle pulses, coincident with the new `hi`/`lo`. Next `start` is accepted in the `done` cycle.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0, state IDLE, counter 0. Reset mid-operation discards all work.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU compute the product with the single-cycle `*` operator.
  - Flow is IDLE→FIX at E0 and HI/LO are written at E1, latency 1.
  - Divide is unchanged.
- `MULDIV_FAST_MUL_EN` undefined: multiply uses the 32-cycle iterative path described above.

## Structure
- Package `muldiv_pkg`:
  - `op` encodings as localparams.
  - State enum (IDLE/CALC/FIX).
  - Default WIDTH.
- Sub-module `muldiv_step` (combinational), one iteration:
  - Shift-add step: accumulator, multiplier bit in, accumulator out.
  - Restoring subtract step: partial remainder, divisor in, remainder/quotient bit out.
  - Instantiated once and muxed by operation type.
- Sign pre-negation and post-correction stay in `muldiv_ctrl`.

## Test plan
- MULTU x=0xFFFFFFFF, y=0xFFFFFFFF → `done` after 33 cycles, hi=0xFFFFFFFE, lo=0x00000001; `busy` high for exactly 33 cycles.
- MULT x=0xFFFFFFFD (−3), y=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. With `MULDIV_FAST_MUL_EN`, the same result 1 cycle after start.
- DIV x=0xFFFFFFF9 (−7), y=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU x=0x12345678, y=0 → after 1 cycle: lo=0xFFFFFFFF, hi=0x12345678, `div_by_zero`=1 and `done`=1 for one cycle.
- Sequence:
  - Preload with MTHI 0xDEADBEEF then MTLO 0x0BADF00D; the regs update the next cycle with `busy`=0.
  - Issue DIVU and assert `cancel` in CALC cycle 10 → `busy`=0 next cycle, hi/lo still 0xDEADBEEF/0x0BADF00D, no `done`.
- During a MULTU, a second `start` (DIVU) is ignored, so the final result equals the MULTU product. `rst` at CALC cycle 5 → hi=lo=0 and `busy`=0 after that edge.
